// File: rtl/aes_core_masked_gen.sv
// aes_core_masked_gen: first-order masked AES encryption core, AES-128 or AES-256.
// The state is kept masked by one replicated byte r. SubBytes goes through a
// 256-entry table S(x ^ r) ^ r that is rebuilt only when r changes.
// Optional fault injection for evaluation builds: define AES_FAULT_INJ_EN.
module aes_core_masked_gen #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plaintext,
    input  logic [KEY_BITS-1:0] key,
    input  logic [7:0]          mask_byte,
    input  logic                fault_inject,
    input  logic [3:0]          fault_round_sel,
    input  logic [6:0]          fault_bit_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        ciphertext,
    output logic                busy
);

    localparam int         ROUNDS   = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_HOLD} state_t;

    // Plain (unmasked) S-box lookup.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] k);
        case (k)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; row 0 is the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [127:0]        r_aes;
    logic [KEY_BITS-1:0] r_key;
    logic [3:0]          r_rnd;
    logic [7:0]          r_cnt;
    logic [7:0]          r_tbl_r;
    logic                r_tbl_valid;
    logic [127:0]        r_ct;
    logic                r_out_valid;
    logic [7:0]          r_tbl [256];

    logic                w_accept;
    logic                w_tbl_hit;
    logic                w_last;
    logic [127:0]        w_sub;
    logic [127:0]        w_shift;
    logic [127:0]        w_mix;
    logic [127:0]        w_round_out;
    logic [127:0]        w_new_state;
    logic [127:0]        w_rk;
    logic [KEY_BITS-1:0] w_key_next;

    assign w_tbl_hit  = r_tbl_valid && (mask_byte == r_tbl_r);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_rnd == LAST_RND);
    assign out_valid  = r_out_valid;
    assign ciphertext = r_ct;

    // State register.
    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_state_next = w_tbl_hit ? S_ROUND : S_INIT;
                end
            end
            S_INIT: begin
                busy = 1'b1;
                if (r_cnt == 8'hff) begin
                    w_state_next = S_ROUND;
                end
            end
            S_ROUND: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Masked SubBytes: a masked byte x^r maps to S(x)^r through the table.
    always_comb begin
        w_sub = '0;
        for (int i = 0; i < 16; i++) begin
            w_sub[127 - 8*i -: 8] = r_tbl[r_aes[127 - 8*i -: 8]];
        end
    end

    // The uniform mask passes through ShiftRows and MixColumns unchanged.
    assign w_shift     = shift_rows(w_sub);
    assign w_mix       = w_last ? w_shift : mix_columns(w_shift);
    assign w_round_out = w_mix ^ w_rk;

`ifdef AES_FAULT_INJ_EN
    logic [127:0] w_fault_mask;
    assign w_fault_mask = (fault_inject && (r_rnd == fault_round_sel)) ?
                          (128'd1 << fault_bit_sel) : '0;
    assign w_new_state  = w_round_out ^ w_fault_mask;
`else
    logic w_unused_fault;
    assign w_unused_fault = ^{fault_inject, fault_round_sel, fault_bit_sel};
    assign w_new_state    = w_round_out;
`endif

    // Key schedule, computed on the fly with the plain S-box.
    generate
        if (KEY_BITS == 128) begin : g_key128
            logic [31:0] w_t, w_k0, w_k1, w_k2, w_k3;
            assign w_t  = sub_word({r_key[23:0], r_key[31:24]}) ^ {rcon(r_rnd), 24'h0};
            assign w_k0 = r_key[127:96] ^ w_t;
            assign w_k1 = r_key[95:64]  ^ w_k0;
            assign w_k2 = r_key[63:32]  ^ w_k1;
            assign w_k3 = r_key[31:0]   ^ w_k2;
            assign w_key_next = {w_k0, w_k1, w_k2, w_k3};
            assign w_rk       = w_key_next;
        end else if (KEY_BITS == 256) begin : g_key256
            // Window {A,B}: round 1 uses B as is; later rounds derive new words from A and B's last word.
            logic [31:0]  w_lw, w_t, w_n0, w_n1, w_n2, w_n3;
            logic [127:0] w_gen;
            assign w_lw  = r_key[31:0];
            assign w_t   = r_rnd[0] ? sub_word(w_lw) :
                           (sub_word({w_lw[23:0], w_lw[31:24]}) ^ {rcon({1'b0, r_rnd[3:1]}), 24'h0});
            assign w_n0  = r_key[255:224] ^ w_t;
            assign w_n1  = r_key[223:192] ^ w_n0;
            assign w_n2  = r_key[191:160] ^ w_n1;
            assign w_n3  = r_key[159:128] ^ w_n2;
            assign w_gen = {w_n0, w_n1, w_n2, w_n3};
            assign w_rk       = (r_rnd == 4'd1) ? r_key[127:0] : w_gen;
            assign w_key_next = (r_rnd == 4'd1) ? r_key : {r_key[127:0], w_gen};
        end else begin : g_key_bad
            $error("aes_core_masked_gen: KEY_BITS must be 128 or 256");
        end
    endgenerate

    // Datapath, round counter, table bookkeeping and output holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aes       <= '0;
            r_key       <= '0;
            r_rnd       <= '0;
            r_cnt       <= '0;
            r_tbl_r     <= '0;
            r_tbl_valid <= 1'b0;
            r_ct        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_aes <= plaintext ^ key[KEY_BITS-1 -: 128] ^ {16{mask_byte}};
                        r_key <= key;
                        r_rnd <= 4'd1;
                        if (!w_tbl_hit) begin
                            r_tbl_r     <= mask_byte;
                            r_tbl_valid <= 1'b0;
                            r_cnt       <= '0;
                        end
                    end
                end
                S_INIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'hff) begin
                        r_tbl_valid <= 1'b1;
                    end
                end
                S_ROUND: begin
                    r_aes <= w_new_state;
                    r_key <= w_key_next;
                    r_rnd <= r_rnd + 4'd1;
                    if (w_last) begin
                        r_ct        <= w_new_state ^ {16{r_tbl_r}};
                        r_out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Masked table build, one entry per INIT cycle.
    // NOTE: the table RAM has no reset; tbl_valid alone says whether its contents are usable.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == S_INIT) begin
            r_tbl[r_cnt] <= sbox(r_cnt ^ r_tbl_r) ^ r_tbl_r;
        end
    end

endmodule

// File: tb/tb_aes_core_masked_gen.sv
// Testbench for aes_core_masked_gen: one AES-128 and one AES-256 instance,
// checked against a textbook AES model (FIPS-style key expansion, S-box
// derived from GF(2^8) inverse + affine map) and a table-validity model.
`timescale 1ns/1ps
module tb_aes_core_masked_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] plaintext;
    logic [7:0]   mask_byte;
    logic         fault_inject;
    logic [3:0]   fault_round_sel;
    logic [6:0]   fault_bit_sel;

    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0] key_a, ct_a;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [255:0] key_b;
    logic [127:0] ct_b;

    aes_core_masked_gen #(.KEY_BITS(128)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .plaintext(plaintext), .key(key_a), .mask_byte(mask_byte),
        .fault_inject(fault_inject), .fault_round_sel(fault_round_sel),
        .fault_bit_sel(fault_bit_sel), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .ciphertext(ct_a), .busy(busy_a)
    );

    aes_core_masked_gen #(.KEY_BITS(256)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .plaintext(plaintext), .key(key_b), .mask_byte(mask_byte),
        .fault_inject(fault_inject), .fault_round_sel(fault_round_sel),
        .fault_bit_sel(fault_bit_sel), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .ciphertext(ct_b), .busy(busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_sbox [256];
    logic       m_tv [2];
    logic [7:0] m_tr [2];
    logic [127:0] exp_ct;
    int           exp_lat;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    // Key is right-aligned in k (AES-128 uses k[127:0]). Optional bit flip after round fr.
    function automatic logic [127:0] ref_encrypt(input logic [255:0] k, input int nk,
                                                 input logic [127:0] pt, input logic fen,
                                                 input int fr, input int fb);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[32*nk - 1 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = subw(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = m_sbox[s[i]];
            for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < nr) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31 - 8*(i%4) -: 8];
            if (fen && r == fr) s[15 - fb/8] ^= 8'(1 << (fb % 8));
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic get_ov(input int d);
        return (d != 0) ? out_valid_b : out_valid_a;
    endfunction
    function automatic logic get_ir(input int d);
        return (d != 0) ? in_ready_b : in_ready_a;
    endfunction
    function automatic logic get_busy(input int d);
        return (d != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic [127:0] get_ct(input int d);
        return (d != 0) ? ct_b : ct_a;
    endfunction
    task automatic set_in_valid(input int d, input logic v);
        if (d != 0) in_valid_b = v; else in_valid_a = v;
    endtask

    // Presents one block and lets it be accepted; computes expected ct and latency.
    task automatic start_block(input int d, input logic [127:0] pt, input logic [255:0] k,
                               input logic [7:0] m);
        logic hit;
        logic fen;
        @(negedge clk);
        plaintext = pt;
        mask_byte = m;
        if (d != 0) key_b = k; else key_a = k[127:0];
        check($sformatf("in_ready_pre_accept_d%0d", d), get_ir(d), 1'b1);
        hit     = m_tv[d] && (m_tr[d] == m);
        exp_lat = (hit ? 0 : 256) + ((d != 0) ? 14 : 10);
        m_tv[d] = 1'b1;
        m_tr[d] = m;
`ifdef AES_FAULT_INJ_EN
        fen = fault_inject;
`else
        fen = 1'b0;
`endif
        exp_ct = ref_encrypt(k, (d != 0) ? 8 : 4, pt, fen, int'(fault_round_sel), int'(fault_bit_sel));
        set_in_valid(d, 1'b1);
        @(posedge clk);
        #1;
        set_in_valid(d, 1'b0);
    endtask

    // Waits for out_valid (bounded); a stray in_valid pulse while busy must be ignored.
    task automatic wait_result(input int d, input string tag);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                check($sformatf("%s_busy", tag), get_busy(d), 1'b1);
                check($sformatf("%s_in_ready_busy", tag), get_ir(d), 1'b0);
            end
            if (lat == 2) begin
                plaintext = ~plaintext;
                set_in_valid(d, 1'b1);
            end
            if (lat == 3) set_in_valid(d, 1'b0);
        end while (!get_ov(d) && lat < 400);
        check($sformatf("%s_latency", tag), lat, exp_lat);
        check($sformatf("%s_ct", tag), get_ct(d), exp_ct);
    endtask

    // One handshake cycle with out_ready already high.
    task automatic finish_block(input int d, input string tag);
        @(posedge clk);
        #1;
        check($sformatf("%s_ov_cleared", tag), get_ov(d), 1'b0);
        check($sformatf("%s_in_ready_after", tag), get_ir(d), 1'b1);
    endtask

    task automatic run_block(input int d, input logic [127:0] pt, input logic [255:0] k,
                             input logic [7:0] m, input string tag);
        start_block(d, pt, k, m);
        wait_result(d, tag);
        finish_block(d, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128   = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [127:0] pt;
        logic [255:0] k;
        logic [7:0]   m;
        logic [7:0]   last_m [2];
        int           d;

        build_sbox();
        m_tv[0] = 1'b0; m_tv[1] = 1'b0;
        m_tr[0] = 8'h00; m_tr[1] = 8'h00;
        rst_n = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        plaintext = '0; key_a = '0; key_b = '0; mask_byte = '0;
        fault_inject = 1'b0; fault_round_sel = '0; fault_bit_sel = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_a", in_ready_a, 1'b0);
        check("rst_in_ready_b", in_ready_b, 1'b0);
        check("rst_out_valid_a", out_valid_a, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        check("rst_ct_a", ct_a, 128'h0);
        check("rst_ct_b", ct_b, 128'h0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready_a", in_ready_a, 1'b1);
        check("idle_in_ready_b", in_ready_b, 1'b1);

        // Known-answer vectors.
        run_block(0, PT_KAT, K128, 8'h5a, "kat128");
        check("kat128_const", ct_a, CT128);
        run_block(1, PT_KAT, K256, 8'ha7, "kat256_build");
        check("kat256_const", ct_b, CT256);
        run_block(1, PT_KAT, K256, 8'ha7, "kat256_hit");
        check("kat256_hit_const", ct_b, CT256);
        run_block(0, PT_KAT, K128, 8'h3c, "kat128_remask");
        check("kat128_remask_const", ct_a, CT128);

        // Back-pressure: result held 20 cycles, in_valid pulse in HOLD dropped.
        out_ready_a = 1'b0;
        start_block(0, PT_KAT, K128, 8'h3c);
        wait_result(0, "hold");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) in_valid_a = 1'b1;
            if (i == 6) in_valid_a = 1'b0;
            check($sformatf("hold_ov_%0d", i), out_valid_a, 1'b1);
            check($sformatf("hold_ct_%0d", i), ct_a, CT128);
            check($sformatf("hold_in_ready_%0d", i), in_ready_a, 1'b0);
        end
        out_ready_a = 1'b1;
        finish_block(0, "hold_release");
        @(posedge clk);
        #1;
        check("hold_single_handshake_ov", out_valid_a, 1'b0);
        check("hold_pulse_dropped_busy", busy_a, 1'b0);

        // Reset in the middle of a table build.
        start_block(0, PT_KAT, K128, 8'h77);
        repeat (100) @(posedge clk);
        #1;
        check("midinit_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midinit_in_ready_in_reset", in_ready_a, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_tv[0] = 1'b0; m_tv[1] = 1'b0;
        #1;
        check("midinit_ov_after_reset", out_valid_a, 1'b0);
        check("midinit_busy_after_reset", busy_a, 1'b0);
        check("midinit_in_ready_after_reset", in_ready_a, 1'b1);
        run_block(0, PT_KAT, K128, 8'h77, "after_reset_rebuild");

        // Fault in the final round, bit 0.
        fault_inject = 1'b1; fault_round_sel = 4'd10; fault_bit_sel = 7'd0;
        run_block(0, PT_KAT, K128, 8'h77, "fault_r10_b0");
`ifdef AES_FAULT_INJ_EN
        check("fault_const", ct_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55b);
`else
        check("fault_const", ct_a, CT128);
`endif
        fault_inject = 1'b0;

        // Randomized blocks, alternating instances, with repeated and zero masks.
        last_m[0] = 8'h77; last_m[1] = 8'ha7;
        for (int n = 0; n < 12; n++) begin
            d  = n % 2;
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (d == 0) k[255:128] = '0;
            if (n < 2)                          m = 8'h00;
            else if ($urandom_range(0, 1) == 1) m = last_m[d];
            else                                m = 8'($urandom);
            last_m[d] = m;
            fault_inject    = (n >= 6);
            fault_round_sel = (n == 6) ? 4'd0 : (n == 7) ? 4'd15 : 4'($urandom_range(1, 10));
            fault_bit_sel   = 7'($urandom_range(0, 127));
            run_block(d, pt, k, m, $sformatf("rand%0d_d%0d", n, d));
        end
        fault_inject = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
